// File: rtl/n_bit_window_comparator_if.sv
// Sample/result bundle for n_bit_window_comparator: operands in, one-hot
// relation plus persistence-filtered relation out.
interface n_bit_window_comparator_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;
    logic [1:0]       stable_rel;
    logic             rel_change;

    modport master (
        output in_valid, a, b, signed_mode,
        input  out_valid, a_gt_b, a_lt_b, a_eq_b, stable_rel, rel_change
    );

    modport slave (
        input  in_valid, a, b, signed_mode,
        output out_valid, a_gt_b, a_lt_b, a_eq_b, stable_rel, rel_change
    );
endinterface

// File: rtl/n_bit_window_comparator.sv
// Registered signed/unsigned magnitude comparator with a persistence filter
// that publishes a relation only after PERSIST consecutive identical samples.
module n_bit_window_comparator #(
    parameter int WIDTH   = 8,
    parameter int PERSIST = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    n_bit_window_comparator_if.slave     bus
);
    localparam int CNT_W = $clog2(PERSIST + 1);

    typedef enum logic [1:0] {
        REL_NONE = 2'b00,
        REL_LT   = 2'b01,
        REL_GT   = 2'b10,
        REL_EQ   = 2'b11
    } rel_e;

    logic             out_valid_q;
    logic             gt_q, lt_q, eq_q;
    rel_e             stable_q;
    logic             rel_change_q;
    rel_e             cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rel_e             rel_d;
    logic             stable_upd;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rel_d = REL_EQ;
        if (bus.signed_mode) begin
            if ($signed(bus.a) > $signed(bus.b))      rel_d = REL_GT;
            else if ($signed(bus.a) < $signed(bus.b)) rel_d = REL_LT;
        end else begin
            if (bus.a > bus.b)      rel_d = REL_GT;
            else if (bus.a < bus.b) rel_d = REL_LT;
        end

        // Saturate at PERSIST so long runs of one relation never wrap the count.
        cand_d = rel_d;
        cnt_d  = CNT_W'(1);
        if (rel_d == cand_q) begin
            cnt_d = (cnt_q == CNT_W'(PERSIST)) ? cnt_q : cnt_q + CNT_W'(1);
        end

        stable_upd = (cnt_d == CNT_W'(PERSIST)) && (rel_d != stable_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: every register, including filter state, is cleared on reset; there
    // is no storage array here that could be left unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            gt_q         <= 1'b0;
            lt_q         <= 1'b0;
            eq_q         <= 1'b0;
            stable_q     <= REL_NONE;
            rel_change_q <= 1'b0;
            cand_q       <= REL_NONE;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= bus.in_valid;
            rel_change_q <= 1'b0;
            if (bus.in_valid) begin
                gt_q   <= (rel_d == REL_GT);
                lt_q   <= (rel_d == REL_LT);
                eq_q   <= (rel_d == REL_EQ);
                cand_q <= cand_d;
                cnt_q  <= cnt_d;
                if (stable_upd) begin
                    stable_q     <= rel_d;
                    rel_change_q <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.a_gt_b     = gt_q;
    assign bus.a_lt_b     = lt_q;
    assign bus.a_eq_b     = eq_q;
    assign bus.stable_rel = stable_q;
    assign bus.rel_change = rel_change_q;
endmodule

// File: tb/tb_n_bit_window_comparator.sv
// Directed bench: WIDTH=8/PERSIST=3 scenarios plus an exhaustive
// WIDTH=4/PERSIST=1 sweep against a reference model.
module tb_n_bit_window_comparator;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   pulses;

    n_bit_window_comparator_if #(.WIDTH(8)) bus8 ();
    n_bit_window_comparator_if #(.WIDTH(4)) bus4 ();

    n_bit_window_comparator #(.WIDTH(8), .PERSIST(3)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    n_bit_window_comparator #(.WIDTH(4), .PERSIST(1)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packed view {out_valid, gt, lt, eq, stable_rel[1:0], rel_change}
    function automatic logic [31:0] obs8();
        return {25'd0, bus8.out_valid, bus8.a_gt_b, bus8.a_lt_b, bus8.a_eq_b,
                bus8.stable_rel, bus8.rel_change};
    endfunction

    function automatic logic [31:0] obs4();
        return {25'd0, bus4.out_valid, bus4.a_gt_b, bus4.a_lt_b, bus4.a_eq_b,
                bus4.stable_rel, bus4.rel_change};
    endfunction

    function automatic logic [31:0] exp_v(input logic ov, input logic gt, input logic lt,
                                          input logic eq, input logic [1:0] st, input logic rc);
        return {25'd0, ov, gt, lt, eq, st, rc};
    endfunction

    // Drive one cycle on the 8-bit DUT; returns on the next falling edge.
    task automatic drv8(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic sm);
        bus8.in_valid    = v;
        bus8.a           = av;
        bus8.b           = bv;
        bus8.signed_mode = sm;
        @(negedge clk);
        bus8.in_valid    = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            bus8.in_valid    = 1'($urandom_range(1));
            bus8.a           = 8'($urandom);
            bus8.b           = 8'($urandom);
            bus8.signed_mode = 1'($urandom_range(1));
            @(negedge clk);
        end
        rst           = 1'b0;
        bus8.in_valid = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus8.in_valid    = 1'b0;
        bus8.a           = '0;
        bus8.b           = '0;
        bus8.signed_mode = 1'b0;
        bus4.in_valid    = 1'b0;
        bus4.a           = '0;
        bus4.b           = '0;
        bus4.signed_mode = 1'b0;
        @(negedge clk);

        // 1. Reset with random inputs, then a partial count
        do_reset(2);
        check("reset_outputs", obs8(), exp_v(0, 0, 0, 0, 2'b00, 0));
        drv8(1, 8'd10, 8'd5, 0);
        check("first_sample", obs8(), exp_v(1, 1, 0, 0, 2'b00, 0));
        drv8(1, 8'd10, 8'd5, 0);
        check("second_sample", obs8(), exp_v(1, 1, 0, 0, 2'b00, 0));
        drv8(1, 8'd10, 8'd5, 0);
        check("third_sample_stable", obs8(), exp_v(1, 1, 0, 0, 2'b10, 1));

        // 2. Signed vs unsigned on the same operands
        drv8(1, 8'hD5, 8'h55, 0);
        check("mode_unsigned_gt", obs8(), exp_v(1, 1, 0, 0, 2'b10, 0));
        drv8(1, 8'hD5, 8'h55, 1);
        check("mode_signed_lt", obs8(), exp_v(1, 0, 1, 0, 2'b10, 0));
        drv8(0, 8'h00, 8'h00, 0);
        check("idle_hold", obs8(), exp_v(0, 0, 1, 0, 2'b10, 0));
        drv8(1, 8'h80, 8'h7F, 1);
        check("signed_min_vs_max", obs8(), exp_v(1, 0, 1, 0, 2'b10, 0));
        drv8(1, 8'h80, 8'h7F, 0);
        check("unsigned_80_vs_7f", obs8(), exp_v(1, 1, 0, 0, 2'b10, 0));

        // 3. Persistence on equality
        drv8(1, 8'hFF, 8'hFF, 0);
        check("eq_1", obs8(), exp_v(1, 0, 0, 1, 2'b10, 0));
        drv8(1, 8'hFF, 8'hFF, 1);
        check("eq_2", obs8(), exp_v(1, 0, 0, 1, 2'b10, 0));
        drv8(1, 8'hFF, 8'hFF, 0);
        check("eq_3_change", obs8(), exp_v(1, 0, 0, 1, 2'b11, 1));
        drv8(1, 8'hFF, 8'hFF, 0);
        check("eq_4_no_change", obs8(), exp_v(1, 0, 0, 1, 2'b11, 0));
        drv8(1, 8'hFF, 8'hFF, 0);
        check("eq_5_saturated", obs8(), exp_v(1, 0, 0, 1, 2'b11, 0));
        drv8(0, 8'h00, 8'h00, 0);
        check("eq_idle", obs8(), exp_v(0, 0, 0, 1, 2'b11, 0));

        // 4. Glitch: gt,gt,lt,gt,gt,gt from a clean reset
        do_reset(1);
        pulses = 0;
        drv8(1, 8'd9, 8'd1, 0); pulses += int'(bus8.rel_change);
        drv8(1, 8'd9, 8'd1, 0); pulses += int'(bus8.rel_change);
        drv8(1, 8'd1, 8'd9, 0); pulses += int'(bus8.rel_change);
        check("glitch_lt", obs8(), exp_v(1, 0, 1, 0, 2'b00, 0));
        drv8(1, 8'd9, 8'd1, 0); pulses += int'(bus8.rel_change);
        drv8(1, 8'd9, 8'd1, 0); pulses += int'(bus8.rel_change);
        check("glitch_5th", obs8(), exp_v(1, 1, 0, 0, 2'b00, 0));
        drv8(1, 8'd9, 8'd1, 0); pulses += int'(bus8.rel_change);
        check("glitch_6th", obs8(), exp_v(1, 1, 0, 0, 2'b10, 1));
        drv8(0, 8'd0, 8'd0, 0); pulses += int'(bus8.rel_change);
        check("glitch_pulse_count", 32'(pulses), 32'd1);

        // 5. Bubbles do not break the run; reset does
        do_reset(1);
        drv8(1, 8'd200, 8'd100, 0);
        for (int i = 0; i < 5; i++) drv8(0, 8'd0, 8'd0, 0);
        check("bubble_idle", obs8(), exp_v(0, 1, 0, 0, 2'b00, 0));
        drv8(1, 8'd200, 8'd100, 0);
        check("bubble_2nd", obs8(), exp_v(1, 1, 0, 0, 2'b00, 0));
        drv8(1, 8'd200, 8'd100, 0);
        check("bubble_3rd", obs8(), exp_v(1, 1, 0, 0, 2'b10, 1));
        do_reset(1);
        drv8(1, 8'd200, 8'd100, 0);
        drv8(1, 8'd200, 8'd100, 0);
        do_reset(1);
        check("mid_reset_clear", obs8(), exp_v(0, 0, 0, 0, 2'b00, 0));
        drv8(1, 8'd200, 8'd100, 0);
        check("mid_reset_3rd", obs8(), exp_v(1, 1, 0, 0, 2'b00, 0));

        // 6. Exhaustive WIDTH=4, PERSIST=1 against a reference model
        do_reset(1);
        begin
            logic [1:0] prev_rel = 2'b00;
            for (int m = 0; m < 2; m++) begin
                for (int ai = 0; ai < 16; ai++) begin
                    for (int bi = 0; bi < 16; bi++) begin
                        int         sa, sb;
                        logic [1:0] rel;
                        sa = (m == 1 && ai >= 8) ? ai - 16 : ai;
                        sb = (m == 1 && bi >= 8) ? bi - 16 : bi;
                        rel = (sa > sb) ? 2'b10 : (sa < sb) ? 2'b01 : 2'b11;
                        bus4.in_valid    = 1'b1;
                        bus4.a           = 4'(ai);
                        bus4.b           = 4'(bi);
                        bus4.signed_mode = 1'(m);
                        @(negedge clk);
                        bus4.in_valid    = 1'b0;
                        check($sformatf("x4 m=%0d a=%0d b=%0d", m, ai, bi), obs4(),
                              exp_v(1, rel == 2'b10, rel == 2'b01, rel == 2'b11, rel,
                                    rel != prev_rel));
                        check($sformatf("x4_onehot m=%0d a=%0d b=%0d", m, ai, bi),
                              32'($countones({bus4.a_gt_b, bus4.a_lt_b, bus4.a_eq_b})), 32'd1);
                        prev_rel = rel;
                    end
                end
            end
        end
        @(negedge clk);
        check("x4_idle", obs4() & 32'h41, 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
